// File: rtl/poly_root_search.sv
// Brute-force root finder for A*x^2 + B*x + C == Y (mod 2^WIDTH), using Horner form on one shared ALU.
// Optional macro POLY_ROOT_COUNT_EN: scan the full range and report the number of roots on sol_count.
module poly_root_search #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] x_result,
    output logic             found,
    output logic             done,
`ifdef POLY_ROOT_COUNT_EN
    output logic [WIDTH:0]   sol_count,
`endif
    output logic             busy
);

    typedef enum logic [3:0] {
        LOAD_A      = 4'd0,
        LOAD_A_WAIT = 4'd1,
        LOAD_B      = 4'd2,
        LOAD_B_WAIT = 4'd3,
        LOAD_C      = 4'd4,
        LOAD_C_WAIT = 4'd5,
        LOAD_Y      = 4'd6,
        LOAD_Y_WAIT = 4'd7,
        EVAL_0      = 4'd8,
        EVAL_1      = 4'd9,
        EVAL_2      = 4'd10,
        EVAL_3      = 4'd11,
        CHECK       = 4'd12,
        DONE        = 4'd13,
        DONE_WAIT   = 4'd14
    } state_t;

    localparam logic [WIDTH-1:0] ONE_X = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef POLY_ROOT_COUNT_EN
    localparam logic [WIDTH:0]   ONE_C = {{WIDTH{1'b0}}, 1'b1};
`endif

    state_t           state, next_state;
    logic [WIDTH-1:0] a_reg, b_reg, c_reg, y_reg;
    logic [WIDTH-1:0] x, t;
    logic             alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic             match, x_last;

    // Shared ALU: op 0 adds, op 1 multiplies; results wrap modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] alu_f(input logic op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        if (op)
            return a * b;
        else
            return a + b;
    endfunction

    assign alu_y  = alu_f(alu_op, alu_a, alu_b);
    assign match  = (t == y_reg);
    assign x_last = (x == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= LOAD_A;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        busy       = 1'b0;
        alu_op     = 1'b0;
        alu_a      = t;
        alu_b      = x;
        case (state)
            LOAD_A:      if (go)  next_state = LOAD_A_WAIT;
            LOAD_A_WAIT: if (!go) next_state = LOAD_B;
            LOAD_B:      if (go)  next_state = LOAD_B_WAIT;
            LOAD_B_WAIT: if (!go) next_state = LOAD_C;
            LOAD_C:      if (go)  next_state = LOAD_C_WAIT;
            LOAD_C_WAIT: if (!go) next_state = LOAD_Y;
            LOAD_Y:      if (go)  next_state = LOAD_Y_WAIT;
            LOAD_Y_WAIT: if (!go) next_state = EVAL_0;
            EVAL_0: begin
                busy       = 1'b1;
                alu_op     = 1'b1;
                alu_a      = a_reg;
                next_state = EVAL_1;
            end
            EVAL_1: begin
                busy       = 1'b1;
                alu_b      = b_reg;
                next_state = EVAL_2;
            end
            EVAL_2: begin
                busy       = 1'b1;
                alu_op     = 1'b1;
                next_state = EVAL_3;
            end
            EVAL_3: begin
                busy       = 1'b1;
                alu_b      = c_reg;
                next_state = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
`ifdef POLY_ROOT_COUNT_EN
                next_state = x_last ? DONE : EVAL_0;
`else
                next_state = (match || x_last) ? DONE : EVAL_0;
`endif
            end
            DONE: begin
                done = 1'b1;
                if (go) next_state = DONE_WAIT;
            end
            DONE_WAIT: begin
                done = 1'b1;
                if (!go) next_state = LOAD_A;
            end
            default: next_state = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            y_reg     <= '0;
            x         <= '0;
            t         <= '0;
            x_result  <= '0;
            found     <= 1'b0;
`ifdef POLY_ROOT_COUNT_EN
            sol_count <= '0;
`endif
        end else begin
            case (state)
                LOAD_A: a_reg <= data_in;
                LOAD_B: b_reg <= data_in;
                LOAD_C: c_reg <= data_in;
                LOAD_Y: y_reg <= data_in;
                LOAD_Y_WAIT: begin
                    if (!go) begin
                        x         <= '0;
                        found     <= 1'b0;
                        x_result  <= '0;
`ifdef POLY_ROOT_COUNT_EN
                        sol_count <= '0;
`endif
                    end
                end
                EVAL_0, EVAL_1, EVAL_2, EVAL_3: t <= alu_y;
                CHECK: begin
`ifdef POLY_ROOT_COUNT_EN
                    // First match wins x_result; later matches only bump the count.
                    if (match) begin
                        sol_count <= sol_count + ONE_C;
                        if (!found) begin
                            x_result <= x;
                            found    <= 1'b1;
                        end
                    end
                    if (!x_last) x <= x + ONE_X;
`else
                    if (match) begin
                        x_result <= x;
                        found    <= 1'b1;
                    end else if (!x_last) begin
                        x <= x + ONE_X;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
